// File: rtl/vpu_pathway_sequencer.sv
// rtl/vpu_pathway_sequencer.sv - holds the VPU pathway select for one pass and tracks lane completion
module vpu_pathway_sequencer #(
    parameter int ROW_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [ROW_W-1:0] num_rows,
    input  logic             abort,
    input  logic             vpu_valid_out_1,
    input  logic             vpu_valid_out_2,
    output logic [3:0]       vpu_data_pathway,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [ROW_W-1:0] rows_done_1,
    output logic [ROW_W-1:0] rows_done_2
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] L_TIMEOUT = 16'(TIMEOUT);

    state_t           r_state;
    logic [3:0]       r_pathway;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [ROW_W-1:0] r_rows;
    logic [ROW_W-1:0] r_cnt1;
    logic [ROW_W-1:0] r_cnt2;
    logic [15:0]      r_idle;

    logic [ROW_W-1:0] w_cnt1_nxt;
    logic [ROW_W-1:0] w_cnt2_nxt;
    logic [15:0]      w_idle_nxt;
    logic             w_any_valid;

    // Bit order: bias | leaky ReLU | loss | leaky ReLU derivative
    function automatic logic [3:0] f_pathway(input logic [1:0] m);
        case (m)
            2'b00:   f_pathway = 4'b1100;
            2'b01:   f_pathway = 4'b1111;
            2'b10:   f_pathway = 4'b0001;
            default: f_pathway = 4'b0000;
        endcase
    endfunction

    // Lane counters saturate at the requested row count so stray valids are ignored
    always_comb begin
        w_cnt1_nxt  = (vpu_valid_out_1 && (r_cnt1 != r_rows)) ? r_cnt1 + ROW_W'(1) : r_cnt1;
        w_cnt2_nxt  = (vpu_valid_out_2 && (r_cnt2 != r_rows)) ? r_cnt2 + ROW_W'(1) : r_cnt2;
        w_idle_nxt  = r_idle + 16'd1;
        w_any_valid = vpu_valid_out_1 | vpu_valid_out_2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pathway <= 4'b0000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_rows    <= '0;
            r_cnt1    <= '0;
            r_cnt2    <= '0;
            r_idle    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        if (mode == 2'b11) begin
                            r_state   <= S_ERROR;
                            r_error   <= 1'b1;
                            r_pathway <= 4'b0000;
                        end else begin
                            r_state   <= S_CONFIG;
                            r_rows    <= num_rows;
                            r_cnt1    <= '0;
                            r_cnt2    <= '0;
                            r_idle    <= '0;
                            r_error   <= 1'b0;
                            r_pathway <= f_pathway(mode);
                            r_busy    <= 1'b1;
                        end
                    end
                end
                S_CONFIG: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_pathway <= 4'b0000;
                        r_busy    <= 1'b0;
                    end else if (r_rows == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_pathway <= 4'b0000;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt1 <= w_cnt1_nxt;
                        r_cnt2 <= w_cnt2_nxt;
                        if ((w_cnt1_nxt == r_rows) && (w_cnt2_nxt == r_rows)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_any_valid) begin
                            r_idle <= '0;
                        end else begin
                            r_idle <= w_idle_nxt;
                            if (w_idle_nxt == L_TIMEOUT) begin
                                r_state   <= S_ERROR;
                                r_error   <= 1'b1;
                                r_pathway <= 4'b0000;
                                r_busy    <= 1'b0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_pathway <= 4'b0000;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pathway <= 4'b0000;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign vpu_data_pathway = r_pathway;
    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign rows_done_1      = r_cnt1;
    assign rows_done_2      = r_cnt2;

endmodule
